// File: rtl/bitwise_op_arbiter.sv
// rtl/bitwise_op_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
// between two valid/ready requesters; one operation in flight at a time.
module bitwise_op_arbiter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_err,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_err,
  output logic         busy,
  output logic [7:0]   done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       r_state, w_next;
  logic         r_grant, r_last_grant;
  logic [2:0]   r_op;
  logic [W-1:0] r_a, r_b, r_data;
  logic         r_err;
  logic [7:0]   r_done_count;

  logic         w_win, w_accept, w_rsp_ready, w_rsp_fire, w_err;
  logic [W-1:0] w_result;

  // On a tie the requester that was not served last wins; otherwise the lone valid one.
  always_comb begin
    w_win = 1'b0;
    if (req0_valid && req1_valid) w_win = ~r_last_grant;
    else                          w_win = ~req0_valid;
  end

  assign w_accept    = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;
  assign w_rsp_fire  = (r_state == RESP) && w_rsp_ready;

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      3'b000:  w_result = r_a & r_b;
      3'b001:  w_result = r_a | r_b;
      3'b010:  w_result = ~r_a;
      3'b011:  w_result = ~(r_a & r_b);
      3'b100:  w_result = ~(r_a | r_b);
      3'b101:  w_result = r_a ^ r_b;
      3'b110:  w_result = ~(r_a ^ r_b);
      default: w_err    = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_next = EXEC;
      EXEC:                    w_next = RESP;
      RESP:    if (w_rsp_fire) w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant <= w_win;
        r_op    <= w_win ? req1_op : req0_op;
        r_a     <= w_win ? req1_a  : req0_a;
        r_b     <= w_win ? req1_b  : req0_b;
      end
      if (r_state == EXEC) begin
        r_data <= w_result;
        r_err  <= w_err;
      end
      if (w_rsp_fire) begin
        r_last_grant <= r_grant;
        r_done_count <= r_done_count + 8'd1;
      end
    end
  end

  assign req0_ready = w_accept && !w_win;
  assign req1_ready = w_accept &&  w_win;
  assign rsp0_valid = (r_state == RESP) && !r_grant;
  assign rsp1_valid = (r_state == RESP) &&  r_grant;
  // Both channels show the shared result register; it only changes while leaving EXEC.
  assign rsp0_data  = r_data;
  assign rsp1_data  = r_data;
  assign rsp0_err   = r_err;
  assign rsp1_err   = r_err;
  assign busy       = (r_state != IDLE);
  assign done_count = r_done_count;

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// tb/tb_bitwise_op_arbiter.sv - self-checking bench for bitwise_op_arbiter
// using directed steps plus randomized transactions against a reference model.
module tb_bitwise_op_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [2:0] req0_op, req0_a, req0_b, rsp0_data;
  logic [2:0] req1_op, req1_a, req1_b, rsp1_data;
  logic       busy;
  logic [7:0] done_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_done = 0;
  int last_g = 1;

  bitwise_op_arbiter #(.W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bit-level arithmetic model of the opcode table.
  function automatic void ref_op(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                 output logic [2:0] d, output logic e);
    int x, y, r;
    e = (op == 3'd7);
    d = 3'd0;
    for (int i = 0; i < 3; i++) begin
      x = int'(a[i]);
      y = int'(b[i]);
      case (op)
        3'd0:    r = x * y;
        3'd1:    r = x + y - x * y;
        3'd2:    r = 1 - x;
        3'd3:    r = 1 - x * y;
        3'd4:    r = 1 - (x + y - x * y);
        3'd5:    r = (x + y) % 2;
        3'd6:    r = 1 - (x + y) % 2;
        default: r = 0;
      endcase
      d[i] = r[0];
    end
  endfunction

  // One full transaction; payloads must already be driven. late1 raises req1_valid mid-operation.
  task automatic txn(input bit v0, input bit v1, input int stall, input bit late1);
    int g;
    logic [2:0] ed;
    logic ee;
    req0_valid = v0;
    req1_valid = v1;
    rsp0_ready = (stall == 0);
    rsp1_ready = (stall == 0);
    g = (v0 && v1) ? 1 - last_g : (v0 ? 0 : 1);
    if (g == 0) ref_op(req0_op, req0_a, req0_b, ed, ee);
    else        ref_op(req1_op, req1_a, req1_b, ed, ee);
    #1;
    chk("req0_ready_idle", 8'(req0_ready), 8'(g == 0));
    chk("req1_ready_idle", 8'(req1_ready), 8'(g == 1));
    tick;
    if (late1) req1_valid = 1'b1;
    #1;
    chk("busy_exec", 8'(busy), 8'd1);
    chk("ready_exec", 8'({req0_ready, req1_ready}), 8'd0);
    chk("rsp_valid_exec", 8'({rsp0_valid, rsp1_valid}), 8'd0);
    tick;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) begin
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
      end
      #1;
      chk("rsp0_valid", 8'(rsp0_valid), 8'(g == 0));
      chk("rsp1_valid", 8'(rsp1_valid), 8'(g == 1));
      chk("rsp_data", 8'((g == 0) ? rsp0_data : rsp1_data), 8'(ed));
      chk("rsp_err", 8'((g == 0) ? rsp0_err : rsp1_err), 8'(ee));
      chk("ready_resp", 8'({req0_ready, req1_ready}), 8'd0);
      if (i < stall) tick;
    end
    tick;
    n_done++;
    last_g = g;
    chk("done_count", done_count, 8'(n_done % 256));
    chk("busy_idle", 8'(busy), 8'd0);
    chk("rsp_valid_idle", 8'({rsp0_valid, rsp1_valid}), 8'd0);
    if (late1) begin
      #1;
      chk("late_req1_ready", 8'(req1_ready), 8'd1);
      chk("late_req0_ready", 8'(req0_ready), 8'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    {req0_op, req0_a, req0_b, req1_op, req1_a, req1_b} = '0;
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", done_count, 8'd0);
    chk("rst_valids", 8'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 8'd0);
    chk("rst_data", 8'({rsp0_data, rsp1_data, rsp0_err, rsp1_err}), 8'd0);
    rst = 1'b0;
    tick;

    req0_op = 3'b000; req0_a = 3'b011; req0_b = 3'b101;
    txn(1'b1, 1'b0, 0, 1'b0);
    chk("single_data", 8'(rsp0_data), 8'd1);

    req1_a = 3'b011; req1_b = 3'b101;
    for (int op = 0; op < 8; op++) begin
      req1_op = 3'(op);
      txn(1'b0, 1'b1, 0, 1'b0);
    end
    chk("illegal_err", 8'({rsp1_err, rsp1_data}), 8'h8);

    req0_op = 3'b000; req0_a = 3'b000; req0_b = 3'b101;
    req1_op = 3'b001; req1_a = 3'b011; req1_b = 3'b101;
    for (int k = 0; k < 4; k++) txn(1'b1, 1'b1, 0, 1'b0);

    req0_op = 3'b101; req0_a = 3'b110; req0_b = 3'b011;
    req1_op = 3'b011; req1_a = 3'b111; req1_b = 3'b010;
    txn(1'b1, 1'b0, 5, 1'b1);
    txn(1'b0, 1'b1, 0, 1'b0);

    req0_op = 3'b001; req0_a = 3'b100; req0_b = 3'b001;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp0_ready = 1'b0;
    tick;
    req0_valid = 1'b0;
    tick;
    chk("pre_rst_rsp0_valid", 8'(rsp0_valid), 8'd1);
    rst = 1'b1;
    #1;
    chk("midrst_rsp0_valid", 8'(rsp0_valid), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_done", done_count, 8'd0);
    rst = 1'b0;
    n_done = 0;
    last_g = 1;
    txn(1'b1, 1'b1, 0, 1'b0);

    for (int k = 0; k < 255; k++) begin
      int vv;
      vv = $urandom_range(1, 3);
      req0_op = 3'($urandom); req0_a = 3'($urandom); req0_b = 3'($urandom);
      req1_op = 3'($urandom); req1_a = 3'($urandom); req1_b = 3'($urandom);
      txn(vv[0], vv[1], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'b0);
    end
    chk("wrap_done", done_count, 8'd0);

    {req0_valid, req1_valid} = '0;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
